// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: four-line interrupt pending/mask register with request/ack/eoi handshake FSM
module irq_pending_ctrl #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq_in,
  input  logic [3:0] mask,
  output logic [3:0] pend_out,
  input  logic [1:0] svc_id,
  output logic       req,
  input  logic       ack,
  input  logic       eoi,
  output logic [3:0] in_service,
  output logic       busy,
  output logic [3:0] ovf,
  input  logic       ovf_clr
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state_q, state_d;
  logic [3:0] irq_prev_q, pending_q, pending_d, in_service_q, in_service_d, ovf_q, ovf_d;
  logic [3:0] set, clr;
  logic ack_ok;
  assign pend_out   = pending_q & mask;
  assign in_service = in_service_q;
  assign ovf        = ovf_q;
  always_comb begin
    set          = EDGE_MODE ? irq_in & ~irq_prev_q : irq_in;
    ack_ok       = state_q == REQ && ack && pend_out[svc_id];
    clr          = ack_ok ? 4'b1 << svc_id : 4'b0;
    pending_d    = (pending_q & ~clr) | set;
    // a fresh overflow outranks a simultaneous clear request
    ovf_d        = (EDGE_MODE ? set & pending_q & ~clr : 4'b0) | (ovf_clr ? 4'b0 : ovf_q);
    in_service_d = ack_ok ? clr : (state_q == SERVICE && eoi) ? 4'b0 : in_service_q;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = |pend_out ? REQ : IDLE;
      REQ:     state_d = ack_ok ? SERVICE : ~|pend_out ? IDLE : REQ;
      SERVICE: state_d = eoi ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req  = state_q == REQ;
    busy = state_q == SERVICE;
  end
  always_ff @(posedge clk)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_prev_q   <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      ovf_q        <= '0;
    end else begin
      irq_prev_q   <= irq_in;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      ovf_q        <= ovf_d;
    end
  end
endmodule
